// File: rtl/palette_loader.sv
// palette_loader: 8-entry runtime-writable RGB palette fed by a byte stream.
// Optional build macro PALETTE_VBLANK_SYNC_EN holds commits until vblank.
module palette_loader #(
    parameter int NCOLORS = 8,
    parameter int CW = 6,
    localparam int IW = $clog2(NCOLORS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          vblank,
    input  logic [IW-1:0] color,
    output logic [CW-1:0] r,
    output logic [CW-1:0] g,
    output logic [CW-1:0] b,
    output logic          busy,
    output logic          frame_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_R,
        S_G,
`ifdef PALETTE_VBLANK_SYNC_EN
        S_B,
        S_PEND
`else
        S_B
`endif
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [CW-1:0] stg_r;
    logic [CW-1:0] stg_g;
    logic [CW-1:0] tbl_r [NCOLORS];
    logic [CW-1:0] tbl_g [NCOLORS];
    logic [CW-1:0] tbl_b [NCOLORS];

    logic          xfer;
    logic          hdr;
    logic [CW-1:0] dat;
    logic          we;
    logic [CW-1:0] wb;

    // Evenly spaced grey level for entry i, full scale at the last entry
    function automatic logic [CW-1:0] grey(input int i);
        int v;
        v = (i * ((1 << CW) - 1)) / (NCOLORS - 1);
        return v[CW-1:0];
    endfunction

    assign xfer = in_valid & in_ready;
    assign hdr  = in_data[7];
    assign dat  = in_data[CW-1:0];

`ifdef PALETTE_VBLANK_SYNC_EN
    logic [CW-1:0] stg_b;
    logic          ready_q;
    logic          unused_bits;

    assign unused_bits = in_data[6];
    assign in_ready    = ready_q;
    assign we          = (state == S_PEND) & vblank;
    assign wb          = stg_b;
`else
    logic unused_bits;

    // Without vblank gating the B byte is written straight through
    assign unused_bits = in_data[6] ^ vblank;
    assign in_ready    = 1'b1;
    assign we          = xfer & ~hdr & (state == S_B);
    assign wb          = dat;
`endif

    // Packet assembly FSM with registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            stg_r     <= '0;
            stg_g     <= '0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
`ifdef PALETTE_VBLANK_SYNC_EN
            stg_b     <= '0;
            ready_q   <= 1'b1;
`endif
        end else begin
            frame_err <= 1'b0;
            if (xfer && hdr) begin
                // A header always starts a fresh packet; mid-packet it aborts
                idx       <= in_data[IW-1:0];
                state     <= S_R;
                busy      <= 1'b1;
                frame_err <= (state != S_IDLE);
            end else if (xfer) begin
                unique case (state)
                    S_IDLE: begin
                        frame_err <= 1'b1;
                    end
                    S_R: begin
                        stg_r <= dat;
                        state <= S_G;
                    end
                    S_G: begin
                        stg_g <= dat;
                        state <= S_B;
                    end
                    S_B: begin
`ifdef PALETTE_VBLANK_SYNC_EN
                        stg_b   <= dat;
                        state   <= S_PEND;
                        ready_q <= 1'b0;
`else
                        state   <= S_IDLE;
                        busy    <= 1'b0;
`endif
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
`ifdef PALETTE_VBLANK_SYNC_EN
            else if (we) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                ready_q <= 1'b1;
            end
`endif
        end
    end

    // Active table: grey ramp at reset, written only by a commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCOLORS; i++) begin
                tbl_r[i] <= grey(i);
                tbl_g[i] <= grey(i);
                tbl_b[i] <= grey(i);
            end
        end else if (we) begin
            tbl_r[idx] <= stg_r;
            tbl_g[idx] <= stg_g;
            tbl_b[idx] <= wb;
        end
    end

    // Registered read port; a same-edge commit shows up one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
            g <= '0;
            b <= '0;
        end else begin
            r <= tbl_r[color];
            g <= tbl_g[color];
            b <= tbl_b[color];
        end
    end

endmodule

// File: doc/palette_loader.md
# palette_loader

Runtime-writable 8-entry palette for the VGA demo pipeline. It accepts a byte stream over a valid/ready handshake, assembles 4-byte packets (header + R, G, B) into a staging entry, and commits each entry to the active table, by default only during vertical blanking. The read side sits between the character generator's 3-bit color index and the 6-bit-per-channel RGB outputs.

## Interface

- `NCOLORS`, default 8: number of palette entries; the index width is log2(NCOLORS), so 3 bits at the default.
- `CW`, default 6: channel width in bits.
- `clk` (input, 1): the single clock.
- `rst_n` (input, 1): asynchronous, active-low reset.
- `in_data` (input, 8): stream byte.
- `in_valid` (input, 1): `in_data` is valid.
- `in_ready` (output, 1): the block can accept a byte this cycle.
- `vblank` (input, 1): vertical blanking level, synchronous to `clk`.
- `color` (input, 3): read index.
- `r`, `g`, `b` (output, CW each): registered palette output for `color`.
- `busy` (output, 1): a packet is in progress or a commit is pending.
- `frame_err` (output, 1): one-cycle pulse on a framing error.

## Operation

**Packet format**
- Header byte: bit7=1; bits2:0 = index; bits6:3 are ignored.
- Data bytes: bit7=0; bits5:0 = channel value; bit6 is ignored.
- Packet order: header, R, G, B.

**Handshake**
- A byte transfers on a rising edge where `in_valid` and `in_ready` are both high.
- `in_ready` is high in every state except PEND.

**FSM states and transitions**
- IDLE
  - Header byte: latch the index, go to R.
  - Data byte: drop it, pulse `frame_err`, stay in IDLE.
- R: a data byte goes to the staging R register, then go to G.
- G: a data byte goes to the staging G register, then go to B.
- B: a data byte goes to the staging B register, then go to PEND.
- Header byte in R, G or B: abort the current packet and pulse `frame_err`. The new index is latched and the FSM goes to R, so the header is consumed, not dropped.
- PEND
  - Wait for `vblank`=1 sampled at a rising edge.
  - On that edge, write the staging {R,G,B} into active entry [index] and return to IDLE.
  - If `vblank` is already high on entry to PEND, the commit happens on the next edge.

**Other outputs and table behaviour**
- `busy` = (state != IDLE).
- Active table reset contents: entry i has r=g=b={i,i} (6 bits), giving the grey ramp 0, 9, 18, …, 63.
- The staging registers and the index reset to 0.
- Only a commit writes the active table. An aborted packet never alters it.

## Timing

- Read latency is 1 cycle: `r`/`g`/`b` at edge n+1 reflect `color` and the active table as sampled at edge n.
- Read/write collision: if a commit writes entry k on edge n while `color`=k, the output after edge n shows the old value. The new value appears after edge n+1.
- Output reset values:
  - `r`=`g`=`b`=0, `in_ready`=1, `busy`=0, `frame_err`=0.
  - The FSM resets to IDLE.
- Reset is asynchronous and takes effect mid-packet or in PEND. The staged entry is discarded and the active table returns to the grey ramp.
- Minimum packet time with `in_valid` held high: 4 cycles, plus at least 1 cycle in PEND.
- `frame_err` is registered and asserts the cycle after the offending transfer. It is never held for more than 1 cycle per offending byte.
- While in PEND, `in_ready`=0 and `in_data` is ignored, whatever `in_valid` is.

## Configuration

- `PALETTE_VBLANK_SYNC_EN` defined: commits wait in PEND for `vblank`, as described above.
- `PALETTE_VBLANK_SYNC_EN` undefined:
  - PEND does not exist; the commit happens on the same edge that accepts the B byte, and the FSM returns to IDLE.
  - `in_ready` is constantly 1.
  - The `vblank` input is ignored.
  - Back-to-back packets run at 4 cycles each.

## Test plan

- Reset: assert `rst_n`=0 mid-packet, release, then sweep `color` 0..7 → `r`/`g`/`b` = 0, 9, 18, 27, 36, 45, 54, 63 one cycle later; `busy`=0.
- Vblank-gated write, with `vblank`=0: send 0x85, 0x3F, 0x00, 0x2A → `busy`=1 and `in_ready`=0 after the B byte; `color`=5 still reads 45/45/45. Then raise `vblank` → next cycle reads 63/0/42, `busy`=0.
- Resync: send 0x81, 0x10, 0x82, 0x01, 0x02, 0x03 → one `frame_err` pulse; entry 1 unchanged (9/9/9); entry 2 = 1/2/3 after commit.
- Stray data byte in IDLE: send 0x15 → `frame_err` pulses once, `busy` stays 0, and no table change.
- Collision: hold `color`=2 across the commit edge of 0x82, 0x3F, 0x3F, 0x3F → output 18/18/18 on the first cycle after the commit, 63/63/63 on the next.
- With the macro undefined: hold `vblank`=0 and stream two packets back to back → `in_ready` never drops; both entries read back updated within 5 cycles of the last byte.
